// File: rtl/check_score_counter_pkg.sv
// ---------------------------------------------------------------------------
// check_pkg : shared FSM state encoding and BCD constants for the scorer
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package check_pkg;

  localparam int        BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    INC  = 2'd2,
    MISS = 2'd3
  } check_state_t;

endpackage

`default_nettype wire

// File: rtl/check_score_counter_if.sv
// ---------------------------------------------------------------------------
// check_score_counter_if : sequencer <-> scorer request and score bundle
// Optional CHECK_MISS_CNT_EN adds the oMisses BCD miss count. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface check_score_counter_if
  import check_pkg::*;
#(
  parameter int VALUE_W = 8,
  parameter int DIGITS  = 2
);

  logic                      iCheck;
  logic [VALUE_W-1:0]        iValue;
  logic [VALUE_W-1:0]        iSwitch;
  logic                      iClear;
  logic [BCD_W*DIGITS-1:0]   oDigits;
  logic                      oBusy;
  logic                      oMatch;
  logic                      oMiss;
  logic                      oOverflow;

`ifdef CHECK_MISS_CNT_EN
  logic [BCD_W*DIGITS-1:0]   oMisses;

  modport master (
    output iCheck, iValue, iSwitch, iClear,
    input  oDigits, oBusy, oMatch, oMiss, oOverflow, oMisses
  );
  modport slave (
    input  iCheck, iValue, iSwitch, iClear,
    output oDigits, oBusy, oMatch, oMiss, oOverflow, oMisses
  );
`else
  modport master (
    output iCheck, iValue, iSwitch, iClear,
    input  oDigits, oBusy, oMatch, oMiss, oOverflow
  );
  modport slave (
    input  iCheck, iValue, iSwitch, iClear,
    output oDigits, oBusy, oMatch, oMiss, oOverflow
  );
`endif

endinterface

`default_nettype wire

// File: rtl/check_score_counter_bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit : one 0..9 counter stage with carry-in/out, clear and hold
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit
  import check_pkg::*;
(
  input  wire logic             iClk,
  input  wire logic             iRst,
  input  wire logic             iInc,
  input  wire logic             iClear,
  input  wire logic             iHold,
  output logic [BCD_W-1:0]      oDigit,
  output logic                  oCarry
);

  logic [BCD_W-1:0] r_digit;

  // Carry depends only on the current digit, never on iHold, so a saturating
  // chain can feed its top carry back as the hold without a loop.
  assign oCarry = iInc && (r_digit == BCD_MAX);
  assign oDigit = r_digit;

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_digit <= '0;
    end else if (iClear) begin
      r_digit <= '0;
    end else if (iInc && !iHold) begin
      r_digit <= (r_digit == BCD_MAX) ? '0 : r_digit + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/check_score_counter.sv
// ---------------------------------------------------------------------------
// check_score_counter : one-shot compare of switch word vs target, N-digit
// BCD match score. Optional CHECK_MISS_CNT_EN adds a BCD miss counter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module check_score_counter
  import check_pkg::*;
#(
  parameter int VALUE_W  = 8,
  parameter int DIGITS   = 2,
  parameter int SATURATE = 1
)(
  input  wire logic              iClk,
  input  wire logic              iRst,
  check_score_counter_if.slave   bus
);

  localparam bit c_sat = (SATURATE != 0);

  check_state_t            r_state;
  check_state_t            w_nextState;
  logic [VALUE_W-1:0]      r_value;
  logic [VALUE_W-1:0]      r_switch;
  logic                    r_match;
  logic                    r_miss;
  logic                    r_overflow;

  logic [DIGITS:0]         w_scoreCarry;
  logic                    w_scoreHold;
  logic [BCD_W*DIGITS-1:0] w_digits;

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state <= IDLE;
    end else if (bus.iClear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.iCheck) w_nextState = CMP;
      CMP:     w_nextState = (r_value == r_switch) ? INC : MISS;
      INC:     w_nextState = IDLE;
      MISS:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operands are captured only on the accepting edge; later input changes are ignored.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_value  <= '0;
      r_switch <= '0;
    end else if ((r_state == IDLE) && bus.iCheck && !bus.iClear) begin
      r_value  <= bus.iValue;
      r_switch <= bus.iSwitch;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_match    <= 1'b0;
      r_miss     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.iClear) begin
      r_match    <= 1'b0;
      r_miss     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_match <= (r_state == INC);
      r_miss  <= (r_state == MISS);
      if (w_scoreCarry[DIGITS]) r_overflow <= 1'b1;
    end
  end

  // A carry out of the top digit means every digit was 9 on this increment.
  assign w_scoreCarry[0] = (r_state == INC);
  assign w_scoreHold     = c_sat && w_scoreCarry[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_score
    bcd_digit u_digit (
      .iClk   (iClk),
      .iRst   (iRst),
      .iInc   (w_scoreCarry[g]),
      .iClear (bus.iClear),
      .iHold  (w_scoreHold),
      .oDigit (w_digits[g*BCD_W +: BCD_W]),
      .oCarry (w_scoreCarry[g+1])
    );
  end

`ifdef CHECK_MISS_CNT_EN
  logic [DIGITS:0]         w_missCarry;
  logic                    w_missHold;
  logic [BCD_W*DIGITS-1:0] w_misses;

  assign w_missCarry[0] = (r_state == MISS);
  assign w_missHold     = c_sat && w_missCarry[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_miss
    bcd_digit u_digit (
      .iClk   (iClk),
      .iRst   (iRst),
      .iInc   (w_missCarry[g]),
      .iClear (bus.iClear),
      .iHold  (w_missHold),
      .oDigit (w_misses[g*BCD_W +: BCD_W]),
      .oCarry (w_missCarry[g+1])
    );
  end

  assign bus.oMisses = w_misses;
`endif

  assign bus.oDigits   = w_digits;
  assign bus.oBusy     = (r_state != IDLE);
  assign bus.oMatch    = r_match;
  assign bus.oMiss     = r_miss;
  assign bus.oOverflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_check_score_counter.sv
// ---------------------------------------------------------------------------
// tb_check_score_counter : saturating and wrapping scorers driven in lockstep
// against an integer score model. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_check_score_counter;

  localparam int VW   = 8;
  localparam int ND   = 2;
  localparam int MAXV = 99;

  logic          iClk = 1'b0;
  logic          iRst = 1'b0;
  logic          check = 1'b0;
  logic          clear = 1'b0;
  logic [VW-1:0] value = '0;
  logic [VW-1:0] sw    = '0;

  int checks = 0;
  int errors = 0;

  int scoreSat, scoreWrap;
  bit ovfSat, ovfWrap;
`ifdef CHECK_MISS_CNT_EN
  int missSat, missWrap;
`endif

  always #5 iClk = ~iClk;

  check_score_counter_if #(.VALUE_W(VW), .DIGITS(ND)) busSat ();
  check_score_counter_if #(.VALUE_W(VW), .DIGITS(ND)) busWrap ();

  assign busSat.iCheck   = check;
  assign busSat.iClear   = clear;
  assign busSat.iValue   = value;
  assign busSat.iSwitch  = sw;
  assign busWrap.iCheck  = check;
  assign busWrap.iClear  = clear;
  assign busWrap.iValue  = value;
  assign busWrap.iSwitch = sw;

  check_score_counter #(.VALUE_W(VW), .DIGITS(ND), .SATURATE(1)) dutSat (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (busSat)
  );

  check_score_counter #(.VALUE_W(VW), .DIGITS(ND), .SATURATE(0)) dutWrap (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (busWrap)
  );

  function automatic logic [4*ND-1:0] bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic modelReset();
    scoreSat = 0; scoreWrap = 0; ovfSat = 0; ovfWrap = 0;
`ifdef CHECK_MISS_CNT_EN
    missSat = 0; missWrap = 0;
`endif
  endtask

  task automatic modelCheck(input bit hit);
    if (hit) begin
      if (scoreSat == MAXV) ovfSat = 1'b1; else scoreSat++;
      if (scoreWrap == MAXV) begin scoreWrap = 0; ovfWrap = 1'b1; end else scoreWrap++;
    end else begin
`ifdef CHECK_MISS_CNT_EN
      missSat  = (missSat == MAXV) ? MAXV : missSat + 1;
      missWrap = (missWrap == MAXV) ? 0 : missWrap + 1;
`endif
    end
  endtask

  task automatic verify(input string tag, input bit eBusy, input bit eMatch, input bit eMiss);
    chk({tag, "/sat.busy"},   32'(busSat.oBusy),      32'(eBusy));
    chk({tag, "/sat.match"},  32'(busSat.oMatch),     32'(eMatch));
    chk({tag, "/sat.miss"},   32'(busSat.oMiss),      32'(eMiss));
    chk({tag, "/sat.digits"}, 32'(busSat.oDigits),    32'(bcd(scoreSat)));
    chk({tag, "/sat.ovf"},    32'(busSat.oOverflow),  32'(ovfSat));
    chk({tag, "/wrap.busy"},  32'(busWrap.oBusy),     32'(eBusy));
    chk({tag, "/wrap.match"}, 32'(busWrap.oMatch),    32'(eMatch));
    chk({tag, "/wrap.miss"},  32'(busWrap.oMiss),     32'(eMiss));
    chk({tag, "/wrap.digits"},32'(busWrap.oDigits),   32'(bcd(scoreWrap)));
    chk({tag, "/wrap.ovf"},   32'(busWrap.oOverflow), 32'(ovfWrap));
`ifdef CHECK_MISS_CNT_EN
    chk({tag, "/sat.misses"}, 32'(busSat.oMisses),    32'(bcd(missSat)));
    chk({tag, "/wrap.misses"},32'(busWrap.oMisses),   32'(bcd(missWrap)));
`endif
  endtask

  // One check request: accepted on the first edge, result two edges later.
  task automatic doCheck(input string tag, input logic [VW-1:0] v, input logic [VW-1:0] s,
                         input bit changeAfter);
    bit hit;
    hit   = (v == s);
    value = v;
    sw    = s;
    check = 1'b1;
    tick();
    check = 1'b0;
    if (changeAfter) sw = v;
    verify({tag, "@N"}, 1'b1, 1'b0, 1'b0);
    tick();
    verify({tag, "@N+1"}, 1'b1, 1'b0, 1'b0);
    tick();
    modelCheck(hit);
    verify({tag, "@N+2"}, 1'b0, hit, !hit);
  endtask

  initial begin
    logic [VW-1:0] rv, rs;
    modelReset();

    // Reset held with a pending request
    iRst  = 1'b0;
    check = 1'b1;
    tick();
    tick();
    check = 1'b0;
    verify("reset", 1'b0, 1'b0, 1'b0);
    iRst = 1'b1;
    tick();
    verify("post_reset", 1'b0, 1'b0, 1'b0);

    doCheck("match_a5", 8'hA5, 8'hA5, 1'b0);
    doCheck("miss_chg", 8'h3C, 8'h3D, 1'b1);

    while (scoreSat < 9) doCheck("fill9", 8'h11, 8'h11, 1'b0);
    doCheck("carry10", 8'h22, 8'h22, 1'b0);
    chk("carry10.bcd", 32'(busSat.oDigits), 32'h10);

    // iCheck held high for nine edges: accepted on edges 0, 3 and 6 only
    value = 8'h55;
    sw    = 8'h55;
    check = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check = 1'b0;
    for (int i = 0; i < 3; i++) modelCheck(1'b1);
    verify("held", 1'b0, 1'b1, 1'b0);
    chk("held.bcd", 32'(busSat.oDigits), 32'h13);
    tick();
    verify("held_after", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rv = VW'($urandom);
      rs = ($urandom_range(0, 1) == 1) ? rv : VW'($urandom);
      doCheck($sformatf("rand%0d", i), rv, rs, 1'b0);
    end

    while (scoreSat < MAXV) doCheck("fill99", 8'h77, 8'h77, 1'b0);
    doCheck("ovf1", 8'h01, 8'h01, 1'b0);
    chk("ovf1.satbcd", 32'(busSat.oDigits), 32'h99);
    chk("ovf1.wrapbcd", 32'(busWrap.oDigits), 32'h00);
    doCheck("ovf2", 8'h02, 8'h02, 1'b0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    modelReset();
    verify("clear", 1'b0, 1'b0, 1'b0);

    // Clear one edge after acceptance aborts the check
    value = 8'h44; sw = 8'h44; check = 1'b1;
    tick();
    check = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    verify("abort_clr@N+1", 1'b0, 1'b0, 1'b0);
    tick();
    verify("abort_clr@N+2", 1'b0, 1'b0, 1'b0);

    doCheck("pre_rst", 8'h66, 8'h66, 1'b0);
    value = 8'h66; sw = 8'h66; check = 1'b1;
    tick();
    check = 1'b0; iRst = 1'b0;
    tick();
    iRst = 1'b1;
    modelReset();
    verify("abort_rst@N+1", 1'b0, 1'b0, 1'b0);
    tick();
    verify("abort_rst@N+2", 1'b0, 1'b0, 1'b0);

    // Simultaneous clear and request: request ignored
    value = 8'h12; sw = 8'h12; check = 1'b1; clear = 1'b1;
    tick();
    check = 1'b0; clear = 1'b0;
    verify("clr_chk@N", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    verify("clr_chk@N+2", 1'b0, 1'b0, 1'b0);

    doCheck("final", 8'hF0, 8'hF0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
